// File: rtl/ballplayer_pkg.sv
// Shared types and helpers for the LED-bar ball game: state encoding, score limit,
// bar length default and the speed-level to step-period mapping.
package ballplayer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        OUT    = 3'd1,
        BACK   = 3'd2,
        WINDOW = 3'd3,
        MISS   = 3'd4
    } state_t;

    localparam logic [6:0]  SCORE_MAX = 7'd99;
    localparam int unsigned N_LED_DEF = 8;
    localparam int unsigned CNT_W     = 23;

    // Faster speed levels halve the step period.
    function automatic logic [CNT_W-1:0] step_period(input int unsigned base,
                                                     input logic [1:0]  k_eff);
        return CNT_W'(base >> k_eff);
    endfunction

endpackage

// File: rtl/ball_motion_speed_ticker.sv
// speed_ticker: step-rate generator for ball_motion. Counts 0..P-1 while enabled and
// flags the last count; a lowered period takes effect immediately.
module speed_ticker
    import ballplayer_pkg::*;
#(
    parameter int unsigned BASE_TICKS = 6_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] k_eff,
    output logic       step
);

    if (BASE_TICKS < 8 || BASE_TICKS >= (1 << CNT_W)) begin : g_bad_base
        $error("speed_ticker: BASE_TICKS out of range");
    end

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;

    assign period = step_period(BASE_TICKS, k_eff);
    // >= rather than == so a count already past a freshly shortened period wraps at once.
    assign step   = en && (cnt >= period - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= step ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ball_motion.sv
// ball_motion: ball on an LED bar with wall bounce, return window, scoring and miss blink.
// Optional BALL_SPEEDUP_EN: speed level rises by one every 4 points (capped at 3).
module ball_motion
    import ballplayer_pkg::*;
#(
    parameter int unsigned BASE_TICKS = 6_000_000,
    parameter int unsigned N_LED      = N_LED_DEF,
    parameter int unsigned MISS_STEPS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       k,
    input  logic             start,
    input  logic             hit,
    output logic [N_LED-1:0] led,
    output logic [6:0]       score,
    output logic             miss,
    output logic             busy
);

    localparam int unsigned POS_W   = (N_LED > 1) ? $clog2(N_LED) : 1;
    localparam int unsigned MSTEP_W = $clog2(MISS_STEPS) + 1;
    localparam logic [POS_W-1:0]   POS_LAST  = POS_W'(N_LED - 1);
    localparam logic [MSTEP_W-1:0] MSTEP_END = MSTEP_W'(MISS_STEPS - 1);
    localparam logic [N_LED-1:0]   LED_ONE   = N_LED'(1);

    state_t             state;
    logic [POS_W-1:0]   pos;
    logic [MSTEP_W-1:0] msteps;
    logic               blink;
    logic [1:0]         k_eff;
    logic               step;

`ifdef BALL_SPEEDUP_EN
    logic [5:0] k_sum;
    assign k_sum = {4'b0, k} + {1'b0, score[6:2]};
    assign k_eff = (k_sum > 6'd3) ? 2'd3 : k_sum[1:0];
`else
    assign k_eff = k;
`endif

    assign busy = (state != IDLE);

    speed_ticker #(
        .BASE_TICKS(BASE_TICKS)
    ) u_ticker (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .clr  (state == IDLE && start),
        .k_eff(k_eff),
        .step (step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pos    <= '0;
            score  <= '0;
            miss   <= 1'b0;
            led    <= '1;
            blink  <= 1'b0;
            msteps <= '0;
        end else begin
            miss <= 1'b0;
            case (state)
                IDLE: begin
                    pos <= '0;
                    if (start) begin
                        state <= OUT;
                        score <= '0;
                    end
                end
                OUT: begin
                    if (step) begin
                        if (pos == POS_LAST) begin
                            state <= BACK;
                            pos   <= pos - 1'b1;
                        end else begin
                            pos <= pos + 1'b1;
                        end
                    end
                end
                BACK: begin
                    if (step) begin
                        pos <= pos - 1'b1;
                        if (pos == POS_W'(1)) state <= WINDOW;
                    end
                end
                WINDOW: begin
                    // A swing landing on the same cycle as the window-closing step still counts.
                    if (hit) begin
                        state <= OUT;
                        if (score < SCORE_MAX) score <= score + 7'd1;
                    end else if (step) begin
                        state  <= MISS;
                        miss   <= 1'b1;
                        blink  <= 1'b1;
                        msteps <= '0;
                    end
                end
                MISS: begin
                    if (step) begin
                        blink <= ~blink;
                        if (msteps == MSTEP_END) state <= IDLE;
                        else msteps <= msteps + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            case (state)
                OUT, BACK, WINDOW: led <= ~(LED_ONE << pos);
                MISS:              led <= blink ? '0 : '1;
                default:           led <= '1;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion with BASE_TICKS=16, MISS_STEPS=2: per-edge vector table
// plus hand sequences for same-cycle hit/step, score saturation, reset mid-rally and speedup.
module tb_ball_motion;

    logic       clk = 1'b0;
    logic       rst, start, hit;
    logic [1:0] k;
    logic [7:0] led;
    logic [6:0] score;
    logic       miss, busy;

    int n_checks = 0;
    int n_fail   = 0;

    ball_motion #(
        .BASE_TICKS(16),
        .N_LED     (8),
        .MISS_STEPS(2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .k    (k),
        .start(start),
        .hit  (hit),
        .led  (led),
        .score(score),
        .miss (miss),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, start, hit;
        logic [1:0] k;
        int         n;
        logic [7:0] led;
        logic [6:0] score;
        logic       miss, busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, s, h, input logic [1:0] kk, input int n,
                                input logic [7:0] l, input logic [6:0] sc, input logic m, b);
        vec_t v;
        v.rst = r; v.start = s; v.hit = h; v.k = kk; v.n = n;
        v.led = l; v.score = sc; v.miss = m; v.busy = b;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        rst = 1'b0; start = 1'b0; hit = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        tick();
        hit = 1'b0;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

`ifdef BALL_SPEEDUP_EN
    task automatic rally_hit(input string name);
        logic [7:0] prev;
        logic       found;
        found = 1'b0;
        for (int t = 0; t < 2000 && !found; t++) begin
            prev = led;
            tick();
            if (prev == 8'hFD && led == 8'hFE) found = 1'b1;
        end
        check(name, {7'b0, found}, 8'h01);
        pulse_hit();
    endtask

    task automatic measure(input string name, input int exp);
        int cyc;
        cyc = 0;
        for (int t = 0; t < 2000 && led != 8'hFD; t++) tick();
        while (led == 8'hFD && cyc < 2000) begin
            tick();
            cyc++;
        end
        check(name, cyc[7:0], exp[7:0]);
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; hit = 1'b0; k = 2'd0;

        // rst start hit k  n   led    score miss busy
        vecs.push_back(mk(1, 0, 0, 0,  1, 8'hFF, 0, 0, 0)); // reset state
        vecs.push_back(mk(0, 1, 0, 0,  1, 8'hFF, 0, 0, 1)); // serve at k=0
        vecs.push_back(mk(0, 0, 0, 0, 16, 8'hFE, 0, 0, 1)); // pos=1 reached, led lags
        vecs.push_back(mk(0, 0, 0, 0,  1, 8'hFD, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0,  9, 8'hFD, 0, 0, 1)); // hit in OUT ignored, cnt=10
        vecs.push_back(mk(0, 1, 0, 3,  1, 8'hFD, 0, 0, 1)); // k->3: step now, start ignored
        vecs.push_back(mk(0, 0, 0, 3,  1, 8'hFB, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 3,  2, 8'hF7, 0, 0, 1)); // then every 2 cycles
        vecs.push_back(mk(0, 0, 0, 3,  8, 8'h7F, 0, 0, 1)); // wall
        vecs.push_back(mk(0, 0, 0, 3,  2, 8'hBF, 0, 0, 1)); // bounced
        vecs.push_back(mk(0, 0, 0, 3, 11, 8'hFD, 0, 0, 1)); // window just entered
        vecs.push_back(mk(0, 0, 1, 3,  1, 8'hFE, 1, 0, 1)); // hit on entry
        vecs.push_back(mk(0, 0, 0, 3,  2, 8'hFD, 1, 0, 1)); // next step -> pos 1
        vecs.push_back(mk(0, 0, 0, 3, 26, 8'hFE, 1, 0, 1)); // window again, no hit
        vecs.push_back(mk(0, 0, 0, 3,  1, 8'hFE, 1, 1, 1)); // miss pulse
        vecs.push_back(mk(0, 0, 0, 3,  1, 8'h00, 1, 0, 1)); // blink on
        vecs.push_back(mk(0, 1, 0, 3,  1, 8'h00, 1, 0, 1)); // start in MISS ignored
        vecs.push_back(mk(0, 0, 0, 3,  1, 8'hFF, 1, 0, 1)); // blink off
        vecs.push_back(mk(0, 0, 0, 3,  1, 8'hFF, 1, 0, 0)); // back to IDLE, score kept

        foreach (vecs[i]) begin
            rst = vecs[i].rst; start = vecs[i].start; hit = vecs[i].hit; k = vecs[i].k;
            tick();
            rst = 1'b0; start = 1'b0; hit = 1'b0;
            for (int j = 1; j < vecs[i].n; j++) tick();
            check($sformatf("v%0d led", i),   led,              vecs[i].led);
            check($sformatf("v%0d score", i), {1'b0, score},    {1'b0, vecs[i].score});
            check($sformatf("v%0d miss", i),  {7'b0, miss},     {7'b0, vecs[i].miss});
            check($sformatf("v%0d busy", i),  {7'b0, busy},     {7'b0, vecs[i].busy});
        end

        // Hit on the same cycle as the window-closing step: hit wins.
        k = 2'd3;
        start = 1'b1;
        tick();
        run(29);
        pulse_hit();
        check("same-cycle score", {1'b0, score}, 8'd1);
        check("same-cycle miss0", {7'b0, miss}, 8'd0);
        run(1);
        check("same-cycle miss1", {7'b0, miss}, 8'd0);
        check("same-cycle busy",  {7'b0, busy}, 8'd1);
        run(2);
        check("same-cycle pos1", led, 8'hFD);

        // Keep the rally going to saturate the score.
        run(26);
        pulse_hit();
        for (int r = 0; r < 97; r++) begin
            run(29);
            pulse_hit();
        end
        check("score reaches 99", {1'b0, score}, 8'd99);
        run(29);
        pulse_hit();
        check("score holds 99", {1'b0, score}, 8'd99);

        // Reset while the ball is travelling back.
        run(17);
        check("mid-BACK led", led, 8'hBF);
        check("mid-BACK busy", {7'b0, busy}, 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst led",   led,              8'hFF);
        check("rst score", {1'b0, score},    8'd0);
        check("rst busy",  {7'b0, busy},     8'd0);
        check("rst miss",  {7'b0, miss},     8'd0);

`ifdef BALL_SPEEDUP_EN
        k = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        measure("speedup P score0", 16);
        for (int h = 0; h < 4; h++) rally_hit($sformatf("speedup window %0d", h));
        measure("speedup P score4", 8);
        for (int h = 4; h < 12; h++) rally_hit($sformatf("speedup window %0d", h));
        measure("speedup P score12", 2);
        rally_hit("speedup window 12");
        measure("speedup P score13", 2);
        check("speedup score", {1'b0, score}, 8'd13);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
